// File: rtl/mem_stage_nlane.sv
// Memory stage for LANES issue slots: per-lane cache response capture, load alignment and flush cancellation.
// Optional lwl/lwr merge logic is built when MS_UNALIGNED_EN is defined.
module mem_stage_nlane #(
    parameter int LANES = 2,
    parameter int CNT_W = 2
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      flush,
    input  logic                      pms_to_ms_valid,
    input  logic [LANES*114-1:0]      pms_to_ms_bus,
    output logic                      ms_allowin,
    input  logic                      ws_allowin,
    output logic                      ms_to_ws_valid,
    output logic [LANES*71-1:0]       ms_to_ws_bus,
    input  logic [LANES-1:0]          data_ok,
    input  logic [LANES*32-1:0]       rdata,
    output logic [2+LANES*39-1:0]     ms_forward_bus
);

    localparam int IN_W  = 114;
    localparam int OUT_W = 71;
    localparam int FWD_W = 39;

    logic                    ms_valid;
    logic [LANES*IN_W-1:0]   bundle;
    logic [LANES-1:0]        live_ok;
    logic [LANES-1:0]        lane_go;
    logic                    ms_ready_go;
    logic                    accept;
    logic                    leave;

    assign ms_ready_go    = &lane_go;
    assign ms_allowin     = !ms_valid | (ms_ready_go & ws_allowin);
    assign ms_to_ws_valid = ms_valid & ms_ready_go & !flush;
    // A flush in the same cycle as an incoming bundle wins: the bundle is refused.
    assign accept         = pms_to_ms_valid & ms_allowin & !flush;
    assign leave          = ms_to_ws_valid & ws_allowin;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid <= 1'b0;
            bundle   <= '0;
        end else begin
            if (flush) begin
                ms_valid <= 1'b0;
            end else if (ms_allowin) begin
                ms_valid <= pms_to_ms_valid;
            end
            if (accept) begin
                bundle <= pms_to_ms_bus;
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [IN_W-1:0]  l;
        logic             lane_valid;
        logic [6:0]       ls_type;
        logic [1:0]       offset;
        logic             res_from_mem;
        logic             mem_we;
        logic             gr_we;
        logic [4:0]       dest;
        logic [31:0]      rt;
        logic [31:0]      alu;
        logic [31:0]      pc;
        logic [31:0]      rd;
        logic [7:0]       byte_v;
        logic [15:0]      half_v;
        logic [31:0]      aligned;
        logic [31:0]      final_result;
        logic             mem_lane;
        logic             capture;
        logic             cnt_inc;
        logic             cnt_dec;
        logic             sat_hit;
        logic             ok_q;
        logic [31:0]      res_q;
        logic [CNT_W-1:0] cnt_q;

        assign l            = bundle[i*IN_W +: IN_W];
        assign lane_valid   = (i == 0) ? 1'b1 : l[113];
        assign ls_type      = l[112:106];
        assign offset       = l[105:104];
        assign res_from_mem = l[103];
        assign mem_we       = l[102];
        assign gr_we        = l[101];
        assign dest         = l[100:96];
        assign rt           = l[95:64];
        assign alu          = l[63:32];
        assign pc           = l[31:0];
        assign rd           = rdata[i*32 +: 32];

        assign byte_v = rd[{offset, 3'b000} +: 8];
        assign half_v = offset[1] ? rd[31:16] : rd[15:0];

        // NOTE: every always_comb output gets a default first so no latch is inferred.
        always_comb begin
            aligned = '0;
            if (ls_type[6]) begin
                aligned = {{24{byte_v[7]}}, byte_v};
            end else if (ls_type[5]) begin
                aligned = {24'b0, byte_v};
            end else if (ls_type[4]) begin
                aligned = {{16{half_v[15]}}, half_v};
            end else if (ls_type[3]) begin
                aligned = {16'b0, half_v};
            end else if (ls_type[2]) begin
                aligned = rd;
`ifdef MS_UNALIGNED_EN
            end else if (ls_type[1]) begin
                case (offset)
                    2'd0:    aligned = {rd[7:0],  rt[23:0]};
                    2'd1:    aligned = {rd[15:0], rt[15:0]};
                    2'd2:    aligned = {rd[23:0], rt[7:0]};
                    default: aligned = rd;
                endcase
            end else if (ls_type[0]) begin
                case (offset)
                    2'd0:    aligned = rd;
                    2'd1:    aligned = {rt[31:24], rd[31:8]};
                    2'd2:    aligned = {rt[31:16], rd[31:16]};
                    default: aligned = {rt[31:8],  rd[31:24]};
                endcase
`endif
            end
        end

`ifndef MS_UNALIGNED_EN
        logic unused_unaligned;
        assign unused_unaligned = ^{rt, ls_type[1:0]};
`endif

        assign mem_lane   = lane_valid & (res_from_mem | mem_we);
        assign live_ok[i] = data_ok[i] & (cnt_q == '0);
        assign lane_go[i] = !mem_lane | ok_q | live_ok[i];

        assign capture = live_ok[i] & ms_valid & !leave & !flush;
        // Responses owed to a flushed bundle are counted so they can be dropped on arrival.
        assign cnt_inc = flush & ms_valid & mem_lane & !ok_q & !live_ok[i];
        assign cnt_dec = data_ok[i] & (cnt_q != '0);
        assign sat_hit = cnt_inc & !cnt_dec & (cnt_q == '1);

        // NOTE: the captured-data register is reset like control state so the output bus reads zero after reset.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                ok_q  <= 1'b0;
                res_q <= '0;
                cnt_q <= '0;
            end else begin
                if (accept | flush) begin
                    ok_q <= 1'b0;
                end else if (capture) begin
                    ok_q <= 1'b1;
                end
                if (capture) begin
                    res_q <= aligned;
                end
                if (cnt_inc && !cnt_dec) begin
                    if (cnt_q != '1) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end else if (cnt_dec && !cnt_inc) begin
                    cnt_q <= cnt_q - CNT_W'(1);
                end
            end
        end

        assert property (@(posedge clk) disable iff (!resetn) !sat_hit)
            else $error("mem_stage_nlane: cancel counter saturated on lane %0d", i);

        assign final_result = ok_q ? res_q : (res_from_mem ? aligned : alu);

        assign ms_to_ws_bus[i*OUT_W +: OUT_W]   = {l[113], gr_we, dest, final_result, pc};
        assign ms_forward_bus[i*FWD_W +: FWD_W] = {res_from_mem, gr_we, dest, final_result};
    end

    assign ms_forward_bus[2+LANES*FWD_W-1 -: 2] = {ms_valid, ms_to_ws_valid};

endmodule

// File: tb/tb_mem_stage_nlane.sv
// Directed bench for mem_stage_nlane (LANES=2): stall capture, split arrival, flush drop, lwl, async reset.
module tb_mem_stage_nlane;

    localparam int LANES = 2;
    localparam int CNT_W = 2;

    localparam logic [6:0] ALU = 7'b0000000;
    localparam logic [6:0] LB  = 7'b1000000;
    localparam logic [6:0] LHU = 7'b0001000;
    localparam logic [6:0] LW  = 7'b0000100;
    localparam logic [6:0] LWL = 7'b0000010;

    logic                   clk = 1'b0;
    logic                   resetn;
    logic                   flush;
    logic                   pms_to_ms_valid;
    logic [LANES*114-1:0]   pms_to_ms_bus;
    logic                   ms_allowin;
    logic                   ws_allowin;
    logic                   ms_to_ws_valid;
    logic [LANES*71-1:0]    ms_to_ws_bus;
    logic [LANES-1:0]       data_ok;
    logic [LANES*32-1:0]    rdata;
    logic [2+LANES*39-1:0]  ms_forward_bus;

    int errors = 0;
    int checks = 0;

    mem_stage_nlane #(.LANES(LANES), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .flush          (flush),
        .pms_to_ms_valid(pms_to_ms_valid),
        .pms_to_ms_bus  (pms_to_ms_bus),
        .ms_allowin     (ms_allowin),
        .ws_allowin     (ws_allowin),
        .ms_to_ws_valid (ms_to_ws_valid),
        .ms_to_ws_bus   (ms_to_ws_bus),
        .data_ok        (data_ok),
        .rdata          (rdata),
        .ms_forward_bus (ms_forward_bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [113:0] mk_lane(input logic [6:0] ls, input logic [1:0] off,
                                             input logic rfm, input logic [31:0] rt,
                                             input logic [31:0] alu, input logic [31:0] pc);
        return {1'b1, ls, off, rfm, 1'b0, 1'b1, 5'd3, rt, alu, pc};
    endfunction

    function automatic logic [31:0] res(input int i);
        return ms_to_ws_bus[i*71+32 +: 32];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] lwl_exp;
`ifdef MS_UNALIGNED_EN
        lwl_exp = 32'h3344CCDD;
`else
        lwl_exp = 32'h00000000;
`endif
        resetn          = 1'b0;
        flush           = 1'b0;
        pms_to_ms_valid = 1'b0;
        pms_to_ms_bus   = '0;
        ws_allowin      = 1'b1;
        data_ok         = '0;
        rdata           = '0;

        #3;
        check("rst_allowin", 64'(ms_allowin), 64'd1);
        check("rst_valid",   64'(ms_to_ws_valid), 64'd0);
        check("rst_bus",     64'(|ms_to_ws_bus), 64'd0);
        check("rst_fwd",     64'(|ms_forward_bus), 64'd0);
        #4 resetn = 1'b1;
        step();

        // Response arrives while writeback stalls; it must be held until ws_allowin.
        ws_allowin      = 1'b0;
        pms_to_ms_valid = 1'b1;
        pms_to_ms_bus   = {mk_lane(ALU, 2'd0, 1'b0, 32'h0, 32'h55, 32'h104),
                           mk_lane(LW,  2'd0, 1'b1, 32'h0, 32'h0,  32'h100)};
        #1 check("s1_allowin_idle", 64'(ms_allowin), 64'd1);
        step();
        pms_to_ms_valid = 1'b0;
        #1;
        check("s1_wait_valid",   64'(ms_to_ws_valid), 64'd0);
        check("s1_wait_allowin", 64'(ms_allowin), 64'd0);
        step();
        data_ok = 2'b01;
        rdata   = {32'h0, 32'h12345678};
        #1;
        check("s1_zero_lat_valid", 64'(ms_to_ws_valid), 64'd1);
        check("s1_zero_lat_res",   64'(res(0)), 64'h12345678);
        step();
        data_ok = 2'b00;
        rdata   = '0;
        #1;
        check("s1_held_valid", 64'(ms_to_ws_valid), 64'd1);
        check("s1_held_res",   64'(res(0)), 64'h12345678);
        step();
        ws_allowin = 1'b1;
        #1;
        check("s1_out_valid",   64'(ms_to_ws_valid), 64'd1);
        check("s1_out_res0",    64'(res(0)), 64'h12345678);
        check("s1_out_res1",    64'(res(1)), 64'h55);
        check("s1_out_allowin", 64'(ms_allowin), 64'd1);
        step();
        #1 check("s1_gone", 64'(ms_to_ws_valid), 64'd0);

        // Split arrival: lane1 early, lane0 two cycles later.
        pms_to_ms_valid = 1'b1;
        pms_to_ms_bus   = {mk_lane(LHU, 2'd2, 1'b1, 32'h0, 32'h0, 32'h204),
                           mk_lane(LB,  2'd3, 1'b1, 32'h0, 32'h0, 32'h200)};
        step();
        pms_to_ms_valid = 1'b0;
        data_ok = 2'b10;
        rdata   = {32'hABCD0000, 32'h0};
        #1 check("s2_c1_valid", 64'(ms_to_ws_valid), 64'd0);
        step();
        data_ok = 2'b00;
        rdata   = '0;
        #1 check("s2_c2_valid", 64'(ms_to_ws_valid), 64'd0);
        step();
        data_ok = 2'b01;
        rdata   = {32'h0, 32'h80FFFFFF};
        #1;
        check("s2_c3_valid", 64'(ms_to_ws_valid), 64'd1);
        check("s2_res0_lb",  64'(res(0)), 64'hFFFFFF80);
        check("s2_res1_lhu", 64'(res(1)), 64'h0000ABCD);
        check("s2_fwd_res0", 64'(ms_forward_bus[31:0]), 64'hFFFFFF80);
        check("s2_fwd_flags", 64'(ms_forward_bus[2+LANES*39-1 -: 2]), 64'd3);
        step();
        data_ok = 2'b00;
        rdata   = '0;
        #1 check("s2_gone", 64'(ms_to_ws_valid), 64'd0);

        // Flush with lane0 load outstanding; the stale response must be dropped.
        pms_to_ms_valid = 1'b1;
        pms_to_ms_bus   = {mk_lane(ALU, 2'd0, 1'b0, 32'h0, 32'h66, 32'h304),
                           mk_lane(LW,  2'd0, 1'b1, 32'h0, 32'h0,  32'h300)};
        step();
        pms_to_ms_valid = 1'b0;
        flush = 1'b1;
        #1 check("s3_flush_valid", 64'(ms_to_ws_valid), 64'd0);
        step();
        flush = 1'b0;
        #1;
        check("s3_cnt_one",   64'(dut.g_lane[0].cnt_q), 64'd1);
        check("s3_flushed",   64'(ms_forward_bus[2+LANES*39-1]), 64'd0);
        pms_to_ms_valid = 1'b1;
        pms_to_ms_bus   = {mk_lane(ALU, 2'd0, 1'b0, 32'h0, 32'h67, 32'h404),
                           mk_lane(LW,  2'd0, 1'b1, 32'h0, 32'h0,  32'h400)};
        step();
        pms_to_ms_valid = 1'b0;
        data_ok = 2'b01;
        rdata   = {32'h0, 32'h0000DEAD};
        #1 check("s3_stale_valid", 64'(ms_to_ws_valid), 64'd0);
        step();
        rdata = {32'h0, 32'h00000BEE};
        #1;
        check("s3_cnt_zero",  64'(dut.g_lane[0].cnt_q), 64'd0);
        check("s3_new_valid", 64'(ms_to_ws_valid), 64'd1);
        check("s3_new_res",   64'(res(0)), 64'h00000BEE);
        step();
        data_ok = 2'b00;
        rdata   = '0;
        #1 check("s3_gone", 64'(ms_to_ws_valid), 64'd0);

        // Flush coinciding with the response and with an incoming bundle.
        pms_to_ms_valid = 1'b1;
        pms_to_ms_bus   = {mk_lane(ALU, 2'd0, 1'b0, 32'h0, 32'h68, 32'h504),
                           mk_lane(LW,  2'd0, 1'b1, 32'h0, 32'h0,  32'h500)};
        step();
        pms_to_ms_bus   = {mk_lane(ALU, 2'd0, 1'b0, 32'h0, 32'h78, 32'h604),
                           mk_lane(ALU, 2'd0, 1'b0, 32'h0, 32'h77, 32'h600)};
        flush   = 1'b1;
        data_ok = 2'b01;
        rdata   = {32'h0, 32'h00000099};
        #1 check("s4_flush_valid", 64'(ms_to_ws_valid), 64'd0);
        step();
        flush           = 1'b0;
        pms_to_ms_valid = 1'b0;
        data_ok         = 2'b00;
        rdata           = '0;
        #1;
        check("s4_cnt_zero",   64'(dut.g_lane[0].cnt_q), 64'd0);
        check("s4_not_taken",  64'(ms_forward_bus[2+LANES*39-1]), 64'd0);
        check("s4_valid",      64'(ms_to_ws_valid), 64'd0);

        // lwl merge, then back-to-back ALU bundles at full rate.
        pms_to_ms_valid = 1'b1;
        pms_to_ms_bus   = {mk_lane(ALU, 2'd0, 1'b0, 32'h0,        32'h22, 32'h704),
                           mk_lane(LWL, 2'd1, 1'b1, 32'hAABBCCDD, 32'h0,  32'h700)};
        step();
        pms_to_ms_valid = 1'b0;
        data_ok = 2'b01;
        rdata   = {32'h0, 32'h11223344};
        #1;
        check("s5_lwl_valid", 64'(ms_to_ws_valid), 64'd1);
        check("s5_lwl_res",   64'(res(0)), 64'(lwl_exp));
        step();
        data_ok = 2'b00;
        rdata   = '0;
        pms_to_ms_valid = 1'b1;
        pms_to_ms_bus   = {mk_lane(ALU, 2'd0, 1'b0, 32'h0, 32'hA1, 32'h804),
                           mk_lane(ALU, 2'd0, 1'b0, 32'h0, 32'hA0, 32'h800)};
        step();
        pms_to_ms_bus   = {mk_lane(ALU, 2'd0, 1'b0, 32'h0, 32'hB1, 32'h904),
                           mk_lane(ALU, 2'd0, 1'b0, 32'h0, 32'hB0, 32'h900)};
        #1;
        check("s5_x_valid",   64'(ms_to_ws_valid), 64'd1);
        check("s5_x_res",     64'(res(0)), 64'hA0);
        check("s5_x_allowin", 64'(ms_allowin), 64'd1);
        step();
        pms_to_ms_valid = 1'b0;
        #1;
        check("s5_y_valid", 64'(ms_to_ws_valid), 64'd1);
        check("s5_y_res",   64'(res(1)), 64'hB1);
        step();
        #1 check("s5_gone", 64'(ms_to_ws_valid), 64'd0);

        // Async reset mid-stall with lane0 captured.
        pms_to_ms_valid = 1'b1;
        pms_to_ms_bus   = {mk_lane(LB, 2'd0, 1'b1, 32'h0, 32'h0, 32'hA04),
                           mk_lane(LW, 2'd0, 1'b1, 32'h0, 32'h0, 32'hA00)};
        step();
        pms_to_ms_valid = 1'b0;
        data_ok = 2'b01;
        rdata   = {32'h0, 32'h0000CAFE};
        #1 check("s6_wait_valid", 64'(ms_to_ws_valid), 64'd0);
        step();
        data_ok = 2'b00;
        rdata   = '0;
        #1 check("s6_captured", 64'(res(0)), 64'h0000CAFE);
        #2 resetn = 1'b0;
        #1;
        check("s6_rst_allowin", 64'(ms_allowin), 64'd1);
        check("s6_rst_valid",   64'(ms_to_ws_valid), 64'd0);
        check("s6_rst_bus",     64'(|ms_to_ws_bus), 64'd0);
        check("s6_rst_fwd",     64'(|ms_forward_bus), 64'd0);
        check("s6_rst_ok",      64'(dut.g_lane[0].ok_q), 64'd0);
        #2 resetn = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
